// File: rtl/zero_scan_unit.sv
// ============================================================================
// Module      : zero_scan_unit
// Description : Multi-cycle leading-zero / leading-one scanner with all-clear
//               detection. Walks the operand CHUNK bits per cycle from the MSB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_scan_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [CW-1:0]    lzc
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // A single-chunk configuration still needs a 1-bit index that never advances
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LW     = $clog2(CHUNK + 1);

    localparam logic [IW-1:0] C_LAST_IDX = IW'(NCHUNK - 1);
    localparam logic [CW-1:0] C_FULL_CNT = CW'(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] r_operand;
    logic [IW-1:0]    r_idx;
    logic             r_done;
    logic             r_zero;
    logic [CW-1:0]    r_lzc;

    logic [CHUNK-1:0] w_chunk;
    logic [LW-1:0]    w_chunk_lz;
    logic             w_hit;
    logic             w_last;
    logic [CW-1:0]    w_count;

    // Chunk 0 is the most significant slice of the operand
    always_comb begin
        w_chunk = r_operand[(NCHUNK - 1 - int'(r_idx)) * CHUNK +: CHUNK];
    end

    // Ascending walk lets the highest set bit overwrite any lower one
    always_comb begin
        w_chunk_lz = LW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (w_chunk[i]) begin
                w_chunk_lz = LW'(CHUNK - 1 - i);
            end
        end
    end

    always_comb begin
        w_hit   = |w_chunk;
        w_last  = (r_idx == C_LAST_IDX);
        w_count = CW'(int'(r_idx) * CHUNK) + CW'(w_chunk_lz);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_hit || w_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (r_state == S_SCAN);
        done = r_done;
        zero = r_zero;
        lzc  = r_lzc;
    end

    // Datapath: operand capture, chunk walk and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_operand <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_zero    <= 1'b0;
            r_lzc     <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    // Leading-ones mode reuses the zero counter on the inverse
                    r_operand <= mode ? ~A : A;
                    r_idx     <= '0;
                end
            end else begin
                if (w_hit) begin
                    r_lzc  <= w_count;
                    r_zero <= 1'b0;
                    r_done <= 1'b1;
                end else if (w_last) begin
                    r_lzc  <= C_FULL_CNT;
                    r_zero <= 1'b1;
                    r_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zero_scan_unit.sv
// ============================================================================
// Module      : tb_zero_scan_unit
// Description : Self-checking bench for zero_scan_unit (WIDTH=32, CHUNK=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zero_scan_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] A;
    logic        busy;
    logic        done;
    logic        zero;
    logic [5:0]  lzc;

    int n_checks = 0;
    int n_fail   = 0;

    // Last result the model expects to be held on zero/lzc
    bit       m_zero = 1'b0;
    int       m_lzc  = 0;

    zero_scan_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mode  (mode),
        .A     (A),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .lzc   (lzc)
    );

    always #5 clk = ~clk;

    // Reference: count leading bits bit-by-bit, derive latency from chunk size
    function automatic void model(input logic [31:0] a, input bit m,
                                  output bit z, output int cnt, output int busy_cycles);
        logic [31:0] x;
        x   = m ? ~a : a;
        cnt = 32;
        for (int i = 31; i >= 0; i--) begin
            if (x[i]) begin
                cnt = 31 - i;
                break;
            end
        end
        z = (cnt == 32);
        busy_cycles = z ? 4 : (cnt / 8) + 1;
    endfunction

    // Launches a scan from a negedge and observes it until done (bounded)
    task automatic run_scan(input logic [31:0] a, input bit m,
                            output int bcnt, output int done_at, output bit ovl,
                            output bit held, output bit z, output logic [5:0] l);
        bcnt = 0; done_at = 0; ovl = 1'b0; held = 1'b1; z = 1'b0; l = '0;
        start = 1'b1; A = a; mode = m;
        @(posedge clk);
        #1;
        start = 1'b0; A = $urandom; mode = 1'($urandom);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (busy && done) ovl = 1'b1;
            if (busy) bcnt++;
            if (done) begin
                done_at = j; z = zero; l = lzc;
                break;
            end
            if (zero !== m_zero || int'(lzc) != m_lzc) held = 1'b0;
        end
    endtask

    task automatic check_scan(input string tag, input logic [31:0] a, input bit m);
        int bcnt, done_at, exp_cnt, exp_busy;
        bit ovl, held, z, exp_z;
        logic [5:0] l;
        model(a, m, exp_z, exp_cnt, exp_busy);
        run_scan(a, m, bcnt, done_at, ovl, held, z, l);
        n_checks++;
        if (done_at !== exp_busy + 1) begin
            n_fail++;
            $display("FAIL %s done_cycle A=%h mode=%0d got %0d want %0d", tag, a, m, done_at, exp_busy + 1);
        end
        n_checks++;
        if (bcnt !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles A=%h mode=%0d got %0d want %0d", tag, a, m, bcnt, exp_busy);
        end
        n_checks++;
        if (ovl !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_done_overlap A=%h got 1 want 0", tag, a);
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result_hold A=%h got changed want held %0d/%0d", tag, a, m_zero, m_lzc);
        end
        n_checks++;
        if (z !== exp_z) begin
            n_fail++;
            $display("FAIL %s zero A=%h mode=%0d got %0d want %0d", tag, a, m, z, exp_z);
        end
        n_checks++;
        if (int'(l) != exp_cnt) begin
            n_fail++;
            $display("FAIL %s lzc A=%h mode=%0d got %0d want %0d", tag, a, m, l, exp_cnt);
        end
        m_zero = exp_z;
        m_lzc  = exp_cnt;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; A = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, zero, lzc} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state got busy=%b done=%b zero=%b lzc=%0d want all 0", busy, done, zero, lzc);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                 32'h0010_0000, 32'hFFFF_FFFF, 32'hFFF0_0000};
        bit          vm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            check_scan("directed", va[k], vm[k]);
        end
    endtask

    task automatic test_back_to_back();
        check_scan("b2b_first", 32'h0000_0001, 1'b0);
        // Still in the done cycle: previous result visible, unit idle
        n_checks++;
        if (busy !== 1'b0 || zero !== 1'b0 || lzc !== 6'd31) begin
            n_fail++;
            $display("FAIL b2b_done_cycle got busy=%b zero=%b lzc=%0d want 0 0 31", busy, zero, lzc);
        end
        check_scan("b2b_second", 32'h0000_8000, 1'b0);
    endtask

    task automatic test_ignore_start();
        int bcnt = 0;
        int done_at = 0;
        int late_busy = 0;
        start = 1'b1; A = 32'h0; mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                done_at = j;
                break;
            end
            if (j == 2) begin
                start = 1'b1; A = 32'h8000_0000; mode = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        end
        n_checks++;
        if (done_at !== 5 || bcnt !== 4) begin
            n_fail++;
            $display("FAIL ignore_start_timing got done_at=%0d busy=%0d want 5 4", done_at, bcnt);
        end
        n_checks++;
        if (zero !== 1'b1 || lzc !== 6'd32) begin
            n_fail++;
            $display("FAIL ignore_start_result got zero=%b lzc=%0d want 1 32", zero, lzc);
        end
        m_zero = 1'b1; m_lzc = 32;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) late_busy++;
        end
        n_checks++;
        if (late_busy !== 0) begin
            n_fail++;
            $display("FAIL ignore_start_queued got %0d active cycles want 0", late_busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
            a = 32'($urandom) >> $urandom_range(0, 32);
            if ($urandom_range(0, 7) == 0) a = '0;
            if ($urandom_range(0, 1) == 1) check_scan("random", ~a, 1'b1);
            else                           check_scan("random", a, 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        int extra = 0;
        check_scan("pre_reset", 32'h0000_0100, 1'b0);
        start = 1'b1; A = 32'h0; mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_busy_before got %b want 1", busy);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, zero, lzc} !== 9'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async got busy=%b done=%b zero=%b lzc=%0d want all 0", busy, done, zero, lzc);
        end
        @(negedge clk);
        rst = 1'b0;
        m_zero = 1'b0; m_lzc = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done got %0d active cycles want 0", extra);
        end
        check_scan("post_reset", 32'h0000_00F0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
